// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, defaults and width helper
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Index/counter widths never collapse to zero bits, even for 1 requester or TIMEOUT=0.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority search from a start index
module rr_pick
  import uart_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  // Visit start, start+1, ... wrapping at N-1; the first requester seen wins.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(start) + k) % N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - message-granular round-robin sharing of one uart_tx byte stream
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ   = 2,
  parameter  int DATA_BITS = UART_DATA_BITS,
  parameter  int TIMEOUT   = 1024,
  localparam int IDX_W     = clog2_min1(NUM_REQ),
  localparam int TO_W      = clog2_min1(TIMEOUT + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [DATA_BITS-1:0]         data,
  output logic                         data_valid,
  input  logic                         data_ready,
  output logic [IDX_W-1:0]             owner,
  output logic                         locked
);

  arb_state_t          state;
  arb_state_t          state_next;
  logic [TO_W-1:0]     idle_cnt;
  logic                slot_free;
  logic                accept;
  logic                acc_last;
  logic                owner_idle;
  logic                cnt_hit;
  logic [IDX_W-1:0]    start_idx;
  logic [IDX_W-1:0]    pick_idx;
  logic [IDX_W-1:0]    grant_idx;
  logic [NUM_REQ-1:0]  pick_gnt;
  logic                pick_any;

  assign slot_free  = !data_valid || data_ready;
  assign start_idx  = (int'(owner) >= NUM_REQ - 1) ? '0 : owner + 1'b1;
  assign grant_idx  = (state == ARB_IDLE) ? pick_idx : owner;
  assign accept     = |(req_valid & req_ready);
  assign acc_last   = req_last[grant_idx];
  assign owner_idle = !req_valid[owner];
  assign locked     = (state == ARB_LOCKED);

  // The counter value seen here is the one before this idle cycle is counted.
  assign cnt_hit = (TIMEOUT != 0) && ((int'(idle_cnt) + 1) >= (TIMEOUT - 1));

  rr_pick #(
    .N (NUM_REQ)
  ) u_rr_pick (
    .req   (req_valid),
    .start (start_idx),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE: begin
        if (accept && !acc_last) begin
          state_next = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (accept) begin
          if (acc_last) begin
            state_next = ARB_IDLE;
          end
        end else if (owner_idle && cnt_hit) begin
          state_next = ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // Reset also masks ready so nothing is offered while rst_n is low.
  always_comb begin
    req_ready = '0;
    if (rst_n && slot_free) begin
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            req_ready = pick_gnt;
          end
        end
        ARB_LOCKED: begin
          req_ready[owner] = req_valid[owner];
        end
        default: req_ready = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= '0;
    end else if (accept && (state == ARB_IDLE)) begin
      owner <= pick_idx;
    end
  end

  // Only a starved owner ages the lock; backpressure leaves the counter alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (state_next == ARB_IDLE) begin
      idle_cnt <= '0;
    end else if (accept) begin
      idle_cnt <= '0;
    end else if ((state == ARB_LOCKED) && owner_idle && (TIMEOUT != 0)) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data       <= '0;
      data_valid <= 1'b0;
    end else if (accept) begin
      data       <= req_data[int'(grant_idx)*DATA_BITS +: DATA_BITS];
      data_valid <= 1'b1;
    end else if (data_ready) begin
      data_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N  = 3;
  localparam int DB = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N*DB-1:0] req_data = '0;
  logic [N-1:0]  req_last = '0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [DB-1:0] data;
  logic          data_valid;
  logic          data_ready = 1'b0;
  logic [1:0]    owner;
  logic          locked;

  uart_tx_arbiter #(
    .NUM_REQ   (N),
    .DATA_BITS (DB),
    .TIMEOUT   (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .owner      (owner),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [8:0] src [N][$];
  bit         en  [N];
  logic [7:0] got_q [$];
  int         grant_q [$];

  logic [7:0]   m_q [$];
  int           m_owner;
  bit           m_locked;
  int           m_cnt;
  logic [N-1:0] m_rdy;
  bit           m_sf;
  int           m_w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_stream(input string name, input logic [7:0] exp [$]);
    chk({name, "_len"}, got_q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      chk(name, (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hdead, {24'h0, exp[i]});
    end
  endtask

  task automatic push(input int i, input logic [8:0] v);
    src[i].push_back(v);
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      if (en[i] && src[i].size() > 0) begin
        req_valid[i]           = 1'b1;
        req_data[i*DB +: DB]   = src[i][0][7:0];
        req_last[i]            = src[i][0][8];
      end else begin
        req_valid[i]           = 1'b0;
        req_data[i*DB +: DB]   = '0;
        req_last[i]            = 1'b0;
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] acc;
    apply_inputs();
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) void'(src[i].pop_front());
    end
    apply_inputs();
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while ((src[0].size() + src[1].size() + src[2].size() != 0 || data_valid) && c < budget) begin
      step();
      c++;
    end
    chk("drain_bound", 32'(c < budget), 1);
  endtask

  task automatic clear_sources();
    for (int i = 0; i < N; i++) begin
      src[i].delete();
      en[i] = 1'b0;
    end
    apply_inputs();
  endtask

  // Reference: one-entry output slot held as a queue, lock/owner/idle count from the arbitration rules.
  initial begin
    m_owner  = 0;
    m_locked = 1'b0;
    m_cnt    = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_q.delete();
        m_owner  = 0;
        m_locked = 1'b0;
        m_cnt    = 0;
      end else begin
        m_sf  = (m_q.size() == 0) || data_ready;
        m_rdy = '0;
        m_w   = -1;
        if (!m_locked) begin
          for (int k = 1; k <= N; k++) begin
            if (m_w < 0 && req_valid[(m_owner + k) % N]) m_w = (m_owner + k) % N;
          end
          if (m_w >= 0 && m_sf) m_rdy[m_w] = 1'b1;
        end else if (m_sf && req_valid[m_owner]) begin
          m_w = m_owner;
          m_rdy[m_owner] = 1'b1;
        end

        chk("req_ready", {29'h0, req_ready}, {29'h0, m_rdy});
        chk("data_valid", {31'h0, data_valid}, 32'(m_q.size() != 0));
        if (m_q.size() != 0) chk("data", {24'h0, data}, {24'h0, m_q[0]});
        chk("owner", {30'h0, owner}, 32'(m_owner));
        chk("locked", {31'h0, locked}, {31'h0, m_locked});

        if (data_valid && data_ready) got_q.push_back(data);
        for (int i = 0; i < N; i++) begin
          if (req_valid[i] && req_ready[i]) grant_q.push_back(i);
        end

        if (data_ready && m_q.size() != 0) void'(m_q.pop_front());
        if (m_rdy != 0) begin
          m_q.push_back(req_data[m_w*DB +: DB]);
          if (!m_locked) begin
            m_owner = m_w;
            if (!req_last[m_w]) begin
              m_locked = 1'b1;
              m_cnt    = 0;
            end
          end else if (req_last[m_w]) begin
            m_locked = 1'b0;
          end else begin
            m_cnt = 0;
          end
        end else if (m_locked && !req_valid[m_owner]) begin
          m_cnt++;
          if (m_cnt == TO - 1) m_locked = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [7:0] exp_s [$];
    int         lk;
    clear_sources();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_valid", {31'h0, data_valid}, 0);
    chk("rst_locked", {31'h0, locked}, 0);
    chk("rst_owner", {30'h0, owner}, 0);
    rst_n = 1'b1;

    // reset asserted while a byte is held in the slot
    push(1, 9'h0A5); push(1, 9'h0A6); en[1] = 1'b1;
    step();
    step();
    chk("pre_rst_data", {24'h0, data}, 32'hA5);
    chk("pre_rst_owner", {30'h0, owner}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_dv", {31'h0, data_valid}, 0);
    chk("async_rst_data", {24'h0, data}, 0);
    chk("async_rst_ready", {29'h0, req_ready}, 0);
    chk("async_rst_owner", {30'h0, owner}, 0);
    chk("async_rst_locked", {31'h0, locked}, 0);
    clear_sources();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    data_ready = 1'b1;
    grant_q.delete();
    push(0, 9'h15A); en[0] = 1'b1;
    step();
    chk("first_grant_req0", (grant_q.size() > 0) ? grant_q[0] : 99, 0);
    drain(10);

    // round-robin fairness with wrap
    grant_q.delete();
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 6; k++) push(i, {1'b1, 8'(8'hA0 + 16*i + k)});
      en[i] = 1'b1;
    end
    repeat (6) step();
    clear_sources();
    drain(10);
    exp_s = '{8'd1, 8'd2, 8'd0, 8'd1, 8'd2, 8'd0};
    chk("rr_count", grant_q.size(), 6);
    for (int k = 0; k < 6; k++) begin
      chk("rr_owner_seq", (k < grant_q.size()) ? grant_q[k] : 99, {24'h0, exp_s[k]});
    end

    // single requester message
    got_q.delete();
    push(0, 9'h048); push(0, 9'h069); push(0, 9'h10A); en[0] = 1'b1;
    step();
    chk("msg_locked_rise", {31'h0, locked}, 1);
    step();
    step();
    chk("msg_locked_fall", {31'h0, locked}, 0);
    step();
    exp_s = '{8'h48, 8'h69, 8'h0A};
    chk_stream("msg_stream", exp_s);

    // contention: req1 waits for req0's whole message
    got_q.delete();
    push(0, 9'h041); push(0, 9'h042); push(0, 9'h10A); en[0] = 1'b1;
    step();
    push(1, 9'h078); push(1, 9'h079); push(1, 9'h10A); en[1] = 1'b1;
    drain(30);
    exp_s = '{8'h41, 8'h42, 8'h0A, 8'h78, 8'h79, 8'h0A};
    chk_stream("contend_stream", exp_s);
    clear_sources();

    // backpressure longer than the timeout must not release the lock
    got_q.delete();
    data_ready = 1'b0;
    push(0, 9'h011); push(0, 9'h022); push(0, 9'h133); en[0] = 1'b1;
    step();
    repeat (20) step();
    chk("bp_data_stable", {24'h0, data}, 32'h11);
    chk("bp_locked", {31'h0, locked}, 1);
    chk("bp_ready_low", {29'h0, req_ready}, 0);
    data_ready = 1'b1;
    repeat (3) step();
    exp_s = '{8'h11, 8'h22, 8'h33};
    chk_stream("bp_stream", exp_s);
    clear_sources();
    drain(10);

    // idle timeout forces release
    got_q.delete();
    push(0, 9'h055); en[0] = 1'b1;
    step();
    push(1, 9'h131); en[1] = 1'b1;
    grant_q.delete();
    lk = 0;
    for (int g = 0; g < 40 && locked; g++) begin
      lk++;
      step();
    end
    chk("timeout_locked_cycles", lk, 15);
    chk("timeout_no_early_grant", grant_q.size(), 0);
    push(0, 9'h156);
    step();
    step();
    chk("timeout_grant_req1", (grant_q.size() > 0) ? grant_q[0] : 99, 1);
    chk("timeout_regrant_req0", (grant_q.size() > 1) ? grant_q[1] : 99, 0);
    drain(10);
    exp_s = '{8'h55, 8'h31, 8'h56};
    chk_stream("timeout_stream", exp_s);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
